// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
//
// Purpose:
//   Bridges spi_slave command words to a single-port RAM and shares that RAM
//   port round-robin with a local host requester. Read data goes back to the
//   SPI side on dout/tx_valid and to the host on host_rdata/host_rvalid.
//
// Build option:
//   SPI_ADDR_AUTOINC_EN  when defined, every accepted SPI write/read post
//                        advances wr_addr/rd_addr by one (wrapping). When not
//                        defined, the SPI addresses change only on 00/10.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   din[9:0], rx_valid               SPI command word ([9:8] opcode) + strobe
//   dout, tx_valid                   SPI read data and its fresh flag
//   host_req/we/addr/wdata           host request (level, held until grant)
//   host_gnt, host_rvalid, host_rdata host grant pulse, read data + strobe
//   ram_en/we/addr/wdata, ram_rdata  RAM port (read latency 1)
//   spi_overflow                     sticky: an SPI data post was dropped
// -----------------------------------------------------------------------------
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            din,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  spi_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_HOST = 1'b0,
        OWNER_SPI  = 1'b1
    } owner_t;

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    state_t                  state;
    owner_t                  owner;       // who owns the access in flight
    owner_t                  last_grant;  // round-robin pointer

    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    // Single pending SPI operation, fully captured when posted so later
    // address-set commands cannot disturb it.
    logic                    spi_pend;
    logic                    pend_we;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [DATA_WIDTH-1:0]   pend_wdata;

    logic [1:0]              opcode;
    logic [ADDR_WIDTH-1:0]   din_addr;
    logic                    post_wr;
    logic                    post_rd;
    logic                    post;
    logic                    slot_free;
    logic                    post_ok;
    logic                    grant_spi;

    assign opcode   = din[9:8];
    assign din_addr = din[ADDR_WIDTH-1:0];
    assign post_wr  = rx_valid && (opcode == OP_WRITE);
    assign post_rd  = rx_valid && (opcode == OP_READ);
    assign post     = post_wr || post_rd;

    // The slot empties at the end of an SPI-owned ISSUE cycle; a post landing
    // on that same edge takes the slot instead of overflowing.
    assign slot_free = (state == ST_ISSUE) && (owner == OWNER_SPI);
    assign post_ok   = post && (!spi_pend || slot_free);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_spi = 1'b0;
        if (state == ST_IDLE && spi_pend &&
            (!host_req || last_grant == OWNER_HOST))
            grant_spi = 1'b1;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= OWNER_HOST;
            last_grant   <= OWNER_HOST;
            wr_addr      <= '0;
            rd_addr      <= '0;
            spi_pend     <= 1'b0;
            pend_we      <= 1'b0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            dout         <= '0;
            tx_valid     <= 1'b0;
            host_gnt     <= 1'b0;
            host_rvalid  <= 1'b0;
            host_rdata   <= '0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            spi_overflow <= 1'b0;
        end else begin
            host_rvalid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_spi) begin
                        ram_en     <= 1'b1;
                        ram_we     <= pend_we;
                        ram_addr   <= pend_addr;
                        ram_wdata  <= pend_wdata;
                        owner      <= OWNER_SPI;
                        last_grant <= OWNER_SPI;
                        state      <= ST_ISSUE;
                    end else if (host_req) begin
                        ram_en     <= 1'b1;
                        ram_we     <= host_we;
                        ram_addr   <= host_addr;
                        ram_wdata  <= host_wdata;
                        host_gnt   <= 1'b1;
                        owner      <= OWNER_HOST;
                        last_grant <= OWNER_HOST;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ram_addr/ram_wdata intentionally hold their values.
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    host_gnt <= 1'b0;
                    state    <= ram_we ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (owner == OWNER_SPI) begin
                        dout     <= ram_rdata;
                        tx_valid <= 1'b1;
                    end else begin
                        host_rdata  <= ram_rdata;
                        host_rvalid <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Address-set opcodes only touch the address registers.
            if (rx_valid && opcode == OP_SET_WR)
                wr_addr <= din_addr;
            if (rx_valid && opcode == OP_SET_RD)
                rd_addr <= din_addr;

            if (post_ok) begin
                spi_pend   <= 1'b1;
                pend_we    <= post_wr;
                pend_addr  <= post_wr ? wr_addr : rd_addr;
                pend_wdata <= din[DATA_WIDTH-1:0];
                // A newly accepted read retires the previous SPI read data,
                // overriding a completion landing on the same edge.
                if (post_rd)
                    tx_valid <= 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
                if (post_wr)
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                else
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
`else
                // Addresses advance only through explicit 00/10 commands.
`endif
            end else if (slot_free) begin
                spi_pend <= 1'b0;
            end

            if (post && spi_pend && !slot_free)
                spi_overflow <= 1'b1;
        end
    end

endmodule
